// File: rtl/ddr4_cmd_initiator.sv
// ddr4_cmd_initiator: closed-page DDR4 command sequencer (ACT -> RD/WR -> PRE) with periodic all-bank refresh.
// Bus outputs are registered from the next state, so a command is on the bus in the cycle its state is occupied.
module ddr4_cmd_initiator #(
    parameter int T_INIT = 500,
    parameter int T_RCD  = 16,
    parameter int T_RAS  = 39,
    parameter int T_RTP  = 9,
    parameter int T_WR   = 30,
    parameter int T_RP   = 16,
    parameter int T_RFC  = 420,
    parameter int T_REFI = 9360
) (
    input  logic        sys_clk,
    input  logic        sys_reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [29:0] req_addr,
    output logic        c0_ddr4_cke,
    output logic        c0_ddr4_cs_n,
    output logic        c0_ddr4_act_n,
    output logic [16:0] c0_ddr4_adr,
    output logic [1:0]  c0_ddr4_ba,
    output logic        c0_ddr4_bg,
    output logic        rd_issue,
    output logic        wr_issue,
    output logic        ref_overrun
);
    function automatic int max2(input int a, input int b);
        return a > b ? a : b;
    endfunction

    localparam int T_MAX = max2(max2(max2(T_INIT, T_RCD), max2(T_RAS, T_RTP)),
                                max2(max2(T_WR, T_RP), T_RFC));
    localparam int CW = $clog2(T_MAX + 1);

    typedef enum logic [3:0] {
        S_INIT, S_IDLE, S_ACT, S_WAIT_RCD, S_CAS, S_WAIT_PRE, S_PRE, S_WAIT_RP, S_REF, S_WAIT_RFC
    } state_t;

    state_t      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, ras_q, ras_d;
    logic [CW:0]   cnt_nx, ras_nx;
    logic        wr_q, wr_d;
    logic [29:0] addr_q, addr_d;
    logic [15:0] tmr_q, tmr_d;
    logic        pend_q, pend_d, ovr_q, ovr_d, tmr_exp, accept, cmd_d;
    logic        cke_d, cs_n_d, act_n_d, rd_d, wri_d;
    logic [16:0] adr_d;

    assign cnt_nx    = {1'b0, cnt_q} + (CW+1)'(1);
    assign ras_nx    = {1'b0, ras_q} + (CW+1)'(1);
    assign req_ready = state_q == S_IDLE && !pend_q;
    assign accept    = req_valid && req_ready;
    assign tmr_exp   = state_q != S_INIT && tmr_q == 16'(T_REFI - 1);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_INIT:             state_d = cnt_nx >= (CW+1)'(T_INIT) ? S_IDLE : S_INIT;
            S_IDLE:             state_d = pend_q ? S_REF : (req_valid ? S_ACT : S_IDLE);
            S_ACT, S_WAIT_RCD:  state_d = cnt_nx >= (CW+1)'(T_RCD) ? S_CAS : S_WAIT_RCD;
            S_CAS, S_WAIT_PRE:  state_d = (ras_nx >= (CW+1)'(T_RAS) &&
                                           cnt_nx >= (CW+1)'(wr_q ? T_WR : T_RTP)) ? S_PRE : S_WAIT_PRE;
            S_PRE, S_WAIT_RP:   state_d = cnt_nx >= (CW+1)'(T_RP) ? S_IDLE : S_WAIT_RP;
            S_REF, S_WAIT_RFC:  state_d = cnt_nx >= (CW+1)'(T_RFC) ? S_IDLE : S_WAIT_RFC;
            default:            state_d = S_INIT;
        endcase
        cmd_d  = state_d inside {S_ACT, S_CAS, S_PRE, S_REF};
        cnt_d  = cmd_d ? '0 : cnt_nx[CW-1:0];
        // Time since ACT saturates once tRAS is met so it cannot wrap during long CAS-to-PRE waits.
        ras_d  = state_d == S_ACT ? '0 : (ras_nx >= (CW+1)'(T_RAS) ? ras_q : ras_nx[CW-1:0]);
        addr_d = accept ? req_addr : addr_q;
        wr_d   = accept ? req_write : wr_q;
        tmr_d  = (state_q == S_INIT || tmr_exp) ? '0 : tmr_q + 16'd1;
        pend_d = tmr_exp || (pend_q && state_d != S_REF);
        ovr_d  = ovr_q || (tmr_exp && pend_q);
        cke_d   = state_d != S_INIT;
        cs_n_d  = !cmd_d;
        act_n_d = state_d != S_ACT;
        adr_d   = state_d == S_ACT ? addr_d[26:10] :
                  state_d == S_CAS ? {wr_d ? 3'b100 : 3'b101, 4'b0000, addr_d[9:0]} :
                  state_d == S_PRE ? 17'h08400 :
                  state_d == S_REF ? 17'h04000 : 17'h1C000;
        rd_d    = state_d == S_CAS && !wr_d;
        wri_d   = state_d == S_CAS && wr_d;
    end

    always_ff @(posedge sys_clk or posedge sys_reset) begin
        if (sys_reset) begin
            state_q       <= S_INIT;
            cnt_q         <= '0;
            ras_q         <= '0;
            wr_q          <= 1'b0;
            addr_q        <= '0;
            tmr_q         <= '0;
            pend_q        <= 1'b0;
            ovr_q         <= 1'b0;
            c0_ddr4_cke   <= 1'b0;
            c0_ddr4_cs_n  <= 1'b1;
            c0_ddr4_act_n <= 1'b1;
            c0_ddr4_adr   <= '0;
            c0_ddr4_ba    <= '0;
            c0_ddr4_bg    <= 1'b0;
            rd_issue      <= 1'b0;
            wr_issue      <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            ras_q         <= ras_d;
            wr_q          <= wr_d;
            addr_q        <= addr_d;
            tmr_q         <= tmr_d;
            pend_q        <= pend_d;
            ovr_q         <= ovr_d;
            c0_ddr4_cke   <= cke_d;
            c0_ddr4_cs_n  <= cs_n_d;
            c0_ddr4_act_n <= act_n_d;
            c0_ddr4_adr   <= adr_d;
            c0_ddr4_ba    <= addr_d[28:27];
            c0_ddr4_bg    <= addr_d[29];
            rd_issue      <= rd_d;
            wr_issue      <= wri_d;
        end
    end

    assign ref_overrun = ovr_q;
endmodule

// File: tb/tb_ddr4_cmd_initiator.sv
// tb_ddr4_cmd_initiator: scoreboard bench; expected bus commands are queued with their cycle when requests are driven.
module tb_ddr4_cmd_initiator;
    localparam logic [3:0] C_ACT = 4'h8, C_REF = 4'h1, C_PRE = 4'h2, C_WR = 4'h4, C_RD = 4'h5;

    typedef struct {
        int          cyc;
        logic [3:0]  cmd;
        logic [16:0] adr;
        logic [1:0]  ba;
        logic        bg;
    } exp_t;

    logic        clk = 1'b0, sys_reset = 1'b1, req_valid = 1'b0, req_write = 1'b0;
    logic [29:0] req_addr = '0;
    logic        req_ready, cke, cs_n, act_n, bg, rd_issue, wr_issue, ref_overrun;
    logic [16:0] adr;
    logic [1:0]  ba;
    int          cyc = 0, base = 0, n_chk = 0, n_pass = 0;
    exp_t        q[$];

    ddr4_cmd_initiator #(
        .T_INIT(10), .T_RCD(3), .T_RAS(8), .T_RTP(2), .T_WR(7), .T_RP(3), .T_RFC(12), .T_REFI(100)
    ) dut (
        .sys_clk(clk), .sys_reset(sys_reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .c0_ddr4_cke(cke), .c0_ddr4_cs_n(cs_n),
        .c0_ddr4_act_n(act_n), .c0_ddr4_adr(adr), .c0_ddr4_ba(ba), .c0_ddr4_bg(bg),
        .rd_issue(rd_issue), .wr_issue(wr_issue), .ref_overrun(ref_overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc - base);
    endtask

    task automatic push(input int rel, input logic [3:0] cmd, input logic [29:0] a, input logic w);
        exp_t e;
        e.cyc = base + rel;
        e.cmd = cmd;
        e.adr = cmd == C_ACT ? a[26:10] : {w ? 3'b100 : 3'b101, 4'b0000, a[9:0]};
        e.ba  = a[28:27];
        e.bg  = a[29];
        q.push_back(e);
    endtask

    task automatic push_txn(input int acc, input logic w, input logic [29:0] a);
        push(acc + 1, C_ACT, a, w);
        push(acc + 4, w ? C_WR : C_RD, a, w);
        push(acc + (w ? 11 : 9), C_PRE, a, w);
    endtask

    task automatic wait_to(input int rel);
        while (cyc < base + rel) @(negedge clk);
    endtask

    task automatic do_init();
        int rel;
        rel = cyc;
        for (int i = 0; i < 20 && !cke; i++) begin
            check("init_cs_n", cs_n, 1);
            @(negedge clk);
        end
        base = cyc;
        check("init_len", base - rel, 10);
        check("init_cke", cke, 1);
        check("init_ready", req_ready, 1);
        check("init_overrun", ref_overrun, 0);
    endtask

    always @(negedge clk) begin
        if (!sys_reset && !cs_n) begin
            if (q.size() == 0) check("unexpected_cmd", {act_n, adr[16:14]}, 4'hF);
            else begin
                exp_t e;
                e = q.pop_front();
                check("cmd_cycle", cyc - base, e.cyc - base);
                check("cmd_code", act_n ? {1'b0, adr[16:14]} : C_ACT, e.cmd);
                if (e.cmd inside {C_ACT, C_RD, C_WR}) begin
                    check("cmd_adr", adr, e.adr);
                    check("cmd_ba", ba, e.ba);
                    check("cmd_bg", bg, e.bg);
                end
                if (e.cmd == C_PRE) check("pre_a10", adr[10], 1);
                check("rd_issue", rd_issue, e.cmd == C_RD);
                check("wr_issue", wr_issue, e.cmd == C_WR);
            end
        end else if (rd_issue || wr_issue) check("stray_issue", {rd_issue, wr_issue}, 0);
    end

    initial begin
        logic [29:0] a1, a2;
        a1 = {1'b1, 2'd2, 17'h1ABCD, 10'h155};
        a2 = {1'b0, 2'd1, 17'h00F0F, 10'h3FF};
        repeat (3) @(negedge clk);
        check("rst_cke", cke, 0);
        check("rst_cs_n", cs_n, 1);
        check("rst_adr", adr, 0);
        check("rst_ready", req_ready, 0);
        sys_reset = 1'b0;
        do_init();
        // read, then write to the same address
        req_valid = 1'b1; req_write = 1'b0; req_addr = a1;
        push_txn(0, 1'b0, a1);
        wait_to(1); req_valid = 1'b0;
        wait_to(2);
        check("wait_deselect", {cs_n, act_n, adr[16:14]}, 5'h1F);
        wait_to(11);
        check("ready_low_wait_rp", req_ready, 0);
        wait_to(12);
        check("ready_back", req_ready, 1);
        req_valid = 1'b1; req_write = 1'b1;
        push_txn(12, 1'b1, a1);
        wait_to(13); req_valid = 1'b0;
        wait_to(25);
        check("ready_low_after_wr", req_ready, 0);
        // back-to-back reads with valid held
        wait_to(26);
        req_valid = 1'b1; req_write = 1'b0; req_addr = a2;
        push_txn(26, 1'b0, a2);
        push_txn(38, 1'b0, a2);
        wait_to(37);
        check("b2b_ready_early", req_ready, 0);
        wait_to(38);
        check("b2b_ready", req_ready, 1);
        wait_to(39); req_valid = 1'b0;
        // idle refresh, request held through tRFC
        push(101, C_REF, a1, 1'b0);
        wait_to(100);
        check("ref_pending_ready", req_ready, 0);
        wait_to(105);
        req_valid = 1'b1; req_write = 1'b1; req_addr = a1;
        check("ready_in_rfc", req_ready, 0);
        push_txn(113, 1'b1, a1);
        wait_to(112);
        check("ready_end_rfc", req_ready, 0);
        wait_to(114); req_valid = 1'b0;
        // refresh expiry coinciding with a valid request
        wait_to(200);
        req_valid = 1'b1; req_write = 1'b0; req_addr = a2;
        check("ref_wins_ready", req_ready, 0);
        push(201, C_REF, a2, 1'b0);
        push_txn(213, 1'b0, a2);
        wait_to(214); req_valid = 1'b0;
        // refresh expiry during a transaction
        wait_to(295);
        req_valid = 1'b1; req_addr = a1;
        push_txn(295, 1'b0, a1);
        push(308, C_REF, a1, 1'b0);
        wait_to(296); req_valid = 1'b0;
        wait_to(307);
        check("ref_after_txn_ready", req_ready, 0);
        // reset between ACT and RD
        wait_to(330);
        req_valid = 1'b1; req_addr = a1;
        push(331, C_ACT, a1, 1'b0);
        wait_to(331); req_valid = 1'b0;
        wait_to(332);
        sys_reset = 1'b1;
        #1;
        check("arst_cke", cke, 0);
        check("arst_bus", {cs_n, act_n, adr, ba, bg}, {2'b11, 20'h0});
        check("arst_issue", {rd_issue, wr_issue, req_ready, ref_overrun}, 0);
        wait_to(336);
        sys_reset = 1'b0;
        do_init();
        repeat (3) @(negedge clk);
        check("queue_drained", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/ddr4_cmd_initiator.md
# ddr4_cmd_initiator

Closed-page DDR4 command initiator driving the single-rank x72 DDR4 command/address bus (c0_ddr4_*) that the on-card DDR4 bank and its simulation model respond to. Accepts one read or write request at a time, sequences ACT → RD/WR → PRE under programmable timing counters, and inserts periodic all-bank REFRESH. The data path is out of scope: the block only emits issue strobes that the DQ/DQS engine uses to launch or capture bursts.

## Interface
Parameters (controller clock cycles):
- T_INIT, 500, cycles after reset release with CKE low before the first command
- T_RCD, 16, ACT to RD/WR
- T_RAS, 39, ACT to PRE minimum
- T_RTP, 9, RD to PRE minimum
- T_WR, 30, WR to PRE minimum (includes CWL + burst + tWR)
- T_RP, 16, PRE to next ACT/REF
- T_RFC, 420, REF to next ACT/REF
- T_REFI, 9360, refresh interval

Ports:
- sys_clk  in  1  controller clock
- sys_reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when valid & ready
- req_write  in  1  1 = write, 0 = read
- req_addr  in  30  {bg[29], ba[28:27], row[26:10], col[9:0]}
- c0_ddr4_cke  out  1  clock enable
- c0_ddr4_cs_n  out  1  chip select
- c0_ddr4_act_n  out  1  activate
- c0_ddr4_adr  out  17  row on ACT; {RAS_n,CAS_n,WE_n} on [16:14] otherwise
- c0_ddr4_ba  out  2  bank address
- c0_ddr4_bg  out  1  bank group
- rd_issue  out  1  one-cycle pulse in the RD command cycle
- wr_issue  out  1  one-cycle pulse in the WR command cycle
- ref_overrun  out  1  sticky: a refresh interval expired while a refresh was already pending

## Operation
- All bus outputs registered. Reset values: cke=0, cs_n=1, act_n=1, adr=0, ba=0, bg=0, rd_issue=0, wr_issue=0, req_ready=0, ref_overrun=0.
- Idle/deselect cycle: cs_n=1, act_n=1, adr[16:14]=3'b111.
- Encodings (cs_n=0): ACT act_n=0, adr=row; with act_n=1: REF 3'b001, PRE 3'b010 with A10=1 (all banks), WR 3'b100, RD 3'b101. RD/WR: adr[9:0]=col, adr[13:10]=0 (no auto-precharge, BL8 fixed).
- States: INIT → IDLE → ACT → WAIT_RCD → CAS → WAIT_PRE → PRE → WAIT_RP → IDLE; IDLE → REF → WAIT_RFC → IDLE.
- INIT: count T_INIT cycles with cke=0; then cke=1, enter IDLE.
- IDLE: if ref_pending, go REF (priority over requests); else req_ready=1 (combinational from state and ref_pending); on valid & ready latch write flag and address, go ACT.
- Every command state drives its command for exactly one cycle; wait states drive deselect.
- PRE issued at max(ACT+T_RAS, CAS+T_RTP) for reads, max(ACT+T_RAS, CAS+T_WR) for writes.
- Refresh timer: 16-bit, counts from leaving INIT, wraps at T_REFI-1 and sets ref_pending; REF clears it. Expiry while already pending sets ref_overrun (cleared only by reset).
- Single outstanding request; req_ready=0 from acceptance until return to IDLE.

## Timing
- Acceptance in cycle A → ACT on bus in A+1 (cycle t).
- RD/WR at t+T_RCD with rd_issue/wr_issue high in the same cycle.
- Next ACT or REF no earlier than PRE+T_RP; REF to next command T_RFC.
- Refresh expiry and request valid in the same IDLE cycle: REF wins, req_ready=0 that cycle.
- Refresh expiry during a transaction: the transaction completes, then REF from IDLE.
- Reset asserted mid-operation: all outputs return to reset values immediately (async), latched request discarded, no issue pulse, refresh timer and pending cleared, INIT restarts after deassertion.
- Timing counters sized to the largest parameter; parameter value 0 is illegal.

## Test plan
Bench parameters: T_INIT=10, T_RCD=3, T_RAS=8, T_RTP=2, T_WR=7, T_RP=3, T_RFC=12, T_REFI=100.
- Reset release → cke=0 and cs_n=1 for 10 cycles, then cke=1, req_ready=1.
- Read bg=1, ba=2, row=0x1ABCD, col=0x155 → ACT t (act_n=0, adr=0x1ABCD, ba=2, bg=1), RD t+3 (adr=0x14155, rd_issue=1), PRE t+8 (adr[16:14]=010, A10=1), req_ready again t+11.
- Write same address → WR t+3 (adr[16:14]=100, wr_issue=1), PRE t+10, next ACT ≥ t+13.
- Back-to-back reads with req_valid held → ACT-to-ACT spacing exactly 12 cycles (accept at t+11, ACT at t+12); no command overlap.
- Idle 100 cycles after INIT → REF (adr[16:14]=001) once, deselect 12 cycles; request arriving mid-WAIT_RFC accepted only after; refresh expiry coinciding with req_valid → REF first.
- Assert sys_reset between ACT and RD → outputs at reset values within the cycle, no rd_issue; after release, INIT of 10 cycles, ref_overrun=0.
